// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU board sequencer: FSM states, display view,
// LED state codes, ALU widths and the operand nibble extension helper.
package alu_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ENTER_OP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SHOW     = 3'd4
  } state_e;

  typedef enum logic {
    VIEW_RESULT = 1'b0,
    VIEW_FLAGS  = 1'b1
  } view_e;

  localparam logic [3:0] LED_ENTER_A  = 4'b0001;
  localparam logic [3:0] LED_ENTER_B  = 4'b0010;
  localparam logic [3:0] LED_ENTER_OP = 4'b0100;
  localparam logic [3:0] LED_EXEC     = 4'b1000;

  // Widens a 4-bit switch entry to a full ALU operand.
  function automatic logic [DATA_W-1:0] extNibble(input logic [3:0] nib, input logic signExt);
    extNibble = signExt ? {{(DATA_W-4){nib[3]}}, nib} : {{(DATA_W-4){1'b0}}, nib};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchronizer, stability counter, debounced
// level and a single-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Synchronize, count consecutive disagreeing samples, flip the level once
  // the run is long enough and pulse on the flip only when it goes high.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Board sequencer for the external combinational ALU: debounced buttons step
// operand/command entry, the result and flags are registered and shown on LEDs.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SIGN_EXT        = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        sw_i,
  input  logic [3:0]        btn_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              carryout_i,
  input  logic              zero_i,
  input  logic              overflow_i,
  output logic [DATA_W-1:0] operandA_o,
  output logic [DATA_W-1:0] operandB_o,
  output logic [CMD_W-1:0]  command_o,
  output logic [3:0]        led_o
);

  logic [3:0] press;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .btn_i  (btn_i[g]),
      .press_o(press[g])
    );
  end

  state_e            state_q, state_d;
  view_e             view_q, view_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [2:0]        flags_q, flags_d;
  logic [3:0]        led_q, led_d;

  // Next-state and capture decode; press[0] restarts entry from any state and
  // the LED code is derived from the next state so the display is registered.
  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (press[0]) begin
      opA_d   = extNibble(sw_i, SIGN_EXT != 0);
      state_d = ST_ENTER_B;
    end else begin
      case (state_q)
        ST_ENTER_B: begin
          if (press[1]) begin
            opB_d   = extNibble(sw_i, SIGN_EXT != 0);
            state_d = ST_ENTER_OP;
          end
        end
        ST_ENTER_OP: begin
          if (press[2]) begin
            cmd_d   = sw_i[CMD_W-1:0];
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_d   = result_i;
          flags_d = {overflow_i, carryout_i, zero_i};
          view_d  = VIEW_RESULT;
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (press[3]) begin
            view_d = (view_q == VIEW_RESULT) ? VIEW_FLAGS : VIEW_RESULT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    case (state_d)
      ST_ENTER_A:  led_d = LED_ENTER_A;
      ST_ENTER_B:  led_d = LED_ENTER_B;
      ST_ENTER_OP: led_d = LED_ENTER_OP;
      ST_EXEC:     led_d = LED_EXEC;
      ST_SHOW:     led_d = (view_d == VIEW_FLAGS) ? {flags_d, 1'b0} : res_d[3:0];
      default:     led_d = LED_ENTER_A;
    endcase
  end

  // FSM state, capture registers and LED register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_ENTER_A;
      view_q  <= VIEW_RESULT;
      opA_q   <= '0;
      opB_q   <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      led_q   <= LED_ENTER_A;
    end else begin
      state_q <= state_d;
      view_q  <= view_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      led_q   <= led_d;
    end
  end

  // Only the low nibble of the stored result reaches the LEDs.
  logic unusedResHi;
  assign unusedResHi = ^res_q[DATA_W-1:4];

  assign operandA_o = opA_q;
  assign operandB_o = opB_q;
  assign command_o  = cmd_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural lab ALU attached.
module tb_alu_seq_ctrl;

  localparam int DEB = 4;

  logic        clk;
  logic        rstN;
  logic [3:0]  sw;
  logic [3:0]  btn;
  logic [31:0] aluResult;
  logic        aluCarry;
  logic        aluZero;
  logic        aluOverflow;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [2:0]  command;
  logic [3:0]  led;

  int testCount = 0;
  int failCount = 0;
  int press1Count = 0;
  int press1Before;

  alu_seq_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SIGN_EXT       (1)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .sw_i      (sw),
    .btn_i     (btn),
    .result_i  (aluResult),
    .carryout_i(aluCarry),
    .zero_i    (aluZero),
    .overflow_i(aluOverflow),
    .operandA_o(operandA),
    .operandB_o(operandB),
    .command_o (command),
    .led_o     (led)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lab ALU model: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
  always_comb begin
    logic [32:0] wide;
    wide        = 33'd0;
    aluResult   = 32'd0;
    aluCarry    = 1'b0;
    aluOverflow = 1'b0;
    case (command)
      3'd0: begin
        wide        = {1'b0, operandA} + {1'b0, operandB};
        aluResult   = wide[31:0];
        aluCarry    = wide[32];
        aluOverflow = (operandA[31] == operandB[31]) && (wide[31] != operandA[31]);
      end
      3'd1: begin
        wide        = {1'b0, operandA} + {1'b0, ~operandB} + 33'd1;
        aluResult   = wide[31:0];
        aluCarry    = wide[32];
        aluOverflow = (operandA[31] != operandB[31]) && (wide[31] != operandA[31]);
      end
      3'd2: aluResult = operandA ^ operandB;
      3'd3: aluResult = {31'd0, $signed(operandA) < $signed(operandB)};
      3'd4: aluResult = operandA & operandB;
      3'd5: aluResult = ~(operandA & operandB);
      3'd6: aluResult = ~(operandA | operandB);
      default: aluResult = operandA | operandB;
    endcase
    aluZero = (aluResult == 32'd0);
  end

  // Counts press[1] pulses, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (dut.press[1] === 1'b1) press1Count++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Sets the switches, raises the buttons and waits until just after the
  // edge that consumes the resulting press pulse.
  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] swVal);
    sw  = swVal;
    btn = mask;
    tick(DEB + 3);
  endtask

  // Releases all buttons and waits for the debounced levels to fall.
  task automatic releaseButtons();
    btn = 4'b0000;
    tick(DEB + 4);
  endtask

  initial begin
    rstN = 1'b0;
    sw   = 4'b0000;
    btn  = 4'b0000;
    tick(2);
    rstN = 1'b1;
    checkOutput("reset led", {28'd0, led}, 32'h1);
    checkOutput("reset opA", operandA, 32'h0);
    checkOutput("reset opB", operandB, 32'h0);
    checkOutput("reset cmd", {29'd0, command}, 32'h0);

    applyStimulus(4'b0100, 4'b0101);
    checkOutput("illegal btn2 led", {28'd0, led}, 32'h1);
    checkOutput("illegal btn2 cmd", {29'd0, command}, 32'h0);
    releaseButtons();

    applyStimulus(4'b0001, 4'b0011);
    checkOutput("add opA", operandA, 32'h3);
    checkOutput("add led B", {28'd0, led}, 32'h2);
    releaseButtons();
    applyStimulus(4'b0010, 4'b0010);
    checkOutput("add opB", operandB, 32'h2);
    checkOutput("add led OP", {28'd0, led}, 32'h4);
    releaseButtons();
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("add led exec", {28'd0, led}, 32'h8);
    tick(1);
    checkOutput("add led result", {28'd0, led}, 32'h5);
    checkOutput("add cmd", {29'd0, command}, 32'h0);
    releaseButtons();

    applyStimulus(4'b0001, 4'b0001);
    releaseButtons();
    applyStimulus(4'b0010, 4'b0001);
    releaseButtons();
    checkOutput("pre-reset led", {28'd0, led}, 32'h4);
    rstN = 1'b0;
    tick(2);
    rstN = 1'b1;
    checkOutput("midreset led", {28'd0, led}, 32'h1);
    checkOutput("midreset opA", operandA, 32'h0);
    checkOutput("midreset opB", operandB, 32'h0);
    checkOutput("midreset cmd", {29'd0, command}, 32'h0);
    applyStimulus(4'b0010, 4'b0110);
    checkOutput("post-reset btn1 led", {28'd0, led}, 32'h1);
    checkOutput("post-reset btn1 opB", operandB, 32'h0);
    releaseButtons();

    applyStimulus(4'b0001, 4'b1000);
    checkOutput("sext opA", operandA, 32'hFFFF_FFF8);
    releaseButtons();
    applyStimulus(4'b0010, 4'b1000);
    checkOutput("sext opB", operandB, 32'hFFFF_FFF8);
    releaseButtons();
    applyStimulus(4'b0100, 4'b0000);
    tick(1);
    checkOutput("sext led result", {28'd0, led}, 32'h0);
    releaseButtons();
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("sext led flags", {28'd0, led}, 32'h4);
    releaseButtons();
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("sext led back", {28'd0, led}, 32'h0);
    releaseButtons();

    applyStimulus(4'b0001, 4'b0111);
    checkOutput("restart led", {28'd0, led}, 32'h2);
    checkOutput("restart opA", operandA, 32'h7);
    releaseButtons();

    applyStimulus(4'b0011, 4'b0110);
    checkOutput("simul opA", operandA, 32'h6);
    checkOutput("simul opB", operandB, 32'hFFFF_FFF8);
    checkOutput("simul led", {28'd0, led}, 32'h2);
    releaseButtons();

    press1Before = press1Count;
    sw = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      btn = 4'b0010;
      tick(2);
      btn = 4'b0000;
      tick(2);
    end
    btn = 4'b0010;
    tick(20);
    checkOutput("bounce press count", press1Count - press1Before, 32'd1);
    checkOutput("bounce opB", operandB, 32'h5);
    checkOutput("bounce led", {28'd0, led}, 32'h4);
    releaseButtons();

    sw  = 4'b1010;
    btn = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      checkOutput($sformatf("latency press k=%0d", k), {31'd0, dut.press[0]}, {31'd0, k == 6});
      if (k == 6) checkOutput("latency opA held", operandA, 32'h6);
      if (k == 7) checkOutput("latency opA captured", operandA, 32'hFFFF_FFFA);
    end
    releaseButtons();
    checkOutput("latency led", {28'd0, led}, 32'h2);

    applyStimulus(4'b0010, 4'b0011);
    releaseButtons();
    applyStimulus(4'b0100, 4'b0001);
    tick(1);
    checkOutput("sub led result", {28'd0, led}, 32'h7);
    checkOutput("sub cmd", {29'd0, command}, 32'h1);
    releaseButtons();
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("sub led flags", {28'd0, led}, 32'h4);
    releaseButtons();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Board-level sequencer for the 32-bit ALU in the lab test harness. Takes four raw push buttons and four switches, debounces the buttons, and steps an FSM that loads operand A, operand B and the command one nibble at a time. It then registers the ALU result and flags and drives the four LEDs. It replaces free-running switch wiring with a deterministic, debounced entry sequence. The ALU stays an external combinational instance: this block drives its inputs and samples its outputs.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed to accept a button level change. Must be ≥1; board build uses 250000.
- SIGN_EXT, 1: 1 sign-extends the 4-bit operand entries to 32 bits; 0 zero-extends them.

- clk  in  1  single system clock
- rst_n  in  1  reset, synchronous, active-low
- sw  in  4  raw switches, sampled directly; assumed static around a press
- btn  in  4  raw push buttons, asynchronous, bouncing
- result  in  32  ALU result
- carryout, zero, overflow  in  1 each  ALU flags
- operandA  out  32  registered ALU operand A
- operandB  out  32  registered ALU operand B
- command  out  3  registered ALU command
- led  out  4  registered display

## Operation
- Per button: 2-flop synchronizer, then a debouncer. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreement in between clears the counter.
- press[i] is a one-cycle pulse on each 0→1 transition of the debounced level. Releases generate nothing.
- FSM states: ENTER_A, ENTER_B, ENTER_OP, EXEC, SHOW.
- press[0] in any state: operandA ← ext(sw), go to ENTER_B.
- press[1] in ENTER_B: operandB ← ext(sw), go to ENTER_OP.
- press[2] in ENTER_OP: command ← sw[2:0], go to EXEC.
- EXEC lasts exactly one cycle. At its closing edge: res_q ← result, flags_q ← {overflow, carryout, zero}, view ← RESULT, go to SHOW.
- press[3] in SHOW: toggle view between RESULT and FLAGS.
- All other presses are ignored with no state change.
- Simultaneous pulses: press[0] wins. Otherwise only the pulse legal in the current state acts.
- led by state:
  - ENTER_A: 4'b0001
  - ENTER_B: 4'b0010
  - ENTER_OP: 4'b0100
  - EXEC: 4'b1000
  - SHOW with view RESULT: res_q[3:0]
  - SHOW with view FLAGS: {flags_q, 1'b0}
- ext(): SIGN_EXT=1 gives {{28{sw[3]}}, sw}; SIGN_EXT=0 gives {28'b0, sw}.

## Timing
- Reset, applied at any edge with rst_n low and overriding everything:
  - state = ENTER_A, led = 4'b0001
  - operandA = 0, operandB = 0, command = 0
  - res_q = 0, flags_q = 0, view = RESULT
  - synchronizers, debounced levels and counters all 0
- A button held through reset release is seen as a fresh press after the debounce time.
- Press latency: raw btn high and stable from edge t gives the synchronized level at t+2 and press high for exactly one cycle at t+2+DEBOUNCE_CYCLES.
- Capture: the register and the state both update on the edge that samples the press pulse.
- Operand or command capture to SHOW is 2 edges (EXEC plus the result register). led shows the result on the first SHOW cycle.
- operandA, operandB and command stay stable from capture through SHOW, so the ALU inputs never change while EXEC samples the result.
- Bounce shorter than DEBOUNCE_CYCLES produces no press. Holding a button produces exactly one press.

## Structure
- Shared package alu_ctrl_pkg holds:
  - state encoding (3-bit localparams)
  - view encoding
  - LED state codes
  - ALU command width (3) and data width (32)
- Sub-module btn_debounce (param DEBOUNCE_CYCLES) contains synchronizer, counter, level and edge pulse. It is instantiated four times.
- The FSM, capture registers and LED mux live in alu_seq_ctrl.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SIGN_EXT=1, with the real ALU instance attached.
- Reset: rst_n=0 for 2 edges mid-sequence (state ENTER_OP) → led=0001, operandA=operandB=0, command=0, next press[1] ignored.
- Basic add: sw=0011 then btn0; sw=0010 then btn1; sw=0000 then btn2 (ADD) → operandA=3, operandB=2, led=0101 two edges after the press[2] pulse.
- Sign extension and flags: A=sw 1000, B=sw 1000, command ADD → operandA=32'hFFFF_FFF8; after btn3 led={overflow,carryout,zero,0}=0100 per ALU (carryout=1); second btn3 returns led=0000.
- Bounce: in ENTER_B, btn1 toggles every 2 cycles for 12 cycles then holds high 20 cycles → exactly one press, one operandB capture, state ENTER_OP.
- Illegal and simultaneous presses:
  - press[2] in ENTER_A → no change.
  - btn0 and btn1 pressed together in ENTER_B → A captured, state stays ENTER_B.
  - btn0 in SHOW → restart, led=0010.
- Latency: btn0 rises at edge t → press pulse at exactly t+6, operandA updates at t+7.
